// File: rtl/jc_pkg.sv
// rtl/jc_pkg.sv - shared types and helpers for the Johnson-counter phase decoder
//
// Purpose: FSM state encoding, the decoded-code record and the phase-count
// helper used by jc_code_decode and jc_phase_decoder.
// Ports: none (package).

package jc_pkg;

  // Widest phase index the decode record can carry (N up to 128).
  localparam int JC_IDX_MAX_W = 8;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } jc_state_e;

  // legal: cnt matched one of the 2N Johnson codes; idx: which one.
  typedef struct packed {
    logic                    legal;
    logic [JC_IDX_MAX_W-1:0] idx;
  } jc_dec_t;

  // An N-bit Johnson counter walks through 2N distinct codes.
  function automatic int jc_phases(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/jc_code_decode.sv
// rtl/jc_code_decode.sv - combinational Johnson code to phase index decoder
//
// Purpose: compares cnt against every legal Johnson code and reports whether
// it is legal and, if so, its phase index. Illegal codes report idx = 0.
// Ports:
//   cnt  in  [0:N-1]  Johnson code, cnt[0] is the shift-in bit
//   dec  out jc_dec_t legal flag and phase index

module jc_code_decode
  import jc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [0:N-1] cnt,
  output jc_dec_t      dec
);

  // Code k: for k <= N the first k bits are ones (filling phase); for k > N
  // the first k-N bits are zeros (draining phase).
  function automatic logic [0:N-1] jc_code(input int k);
    logic [0:N-1] pat;
    for (int i = 0; i < N; i++) begin
      pat[i] = (k <= N) ? (i < k) : (i >= k - N);
    end
    return pat;
  endfunction

  always_comb begin
    dec = '0;
    for (int k = 0; k < jc_phases(N); k++) begin
      if (cnt == jc_code(k)) begin
        dec.legal = 1'b1;
        dec.idx   = JC_IDX_MAX_W'(k);
      end
    end
  end

endmodule

// File: rtl/jc_phase_decoder.sv
// rtl/jc_phase_decoder.sv - registered Johnson-counter phase decoder with lock and fault tracking
//
// Purpose: decodes the upstream Johnson counter into a phase index and a
// one-hot phase vector, locks after two legal samples joined by a legal step,
// latches a sticky error on any illegal code or step, and pulses cycle_tick on
// each 2N-1 -> 0 wrap. Optional macro JC_CYCLE_COUNT_EN adds the cycle_cnt
// revolution counter.
// Ports:
//   clk           in   clock, shared with the counter
//   rst           in   asynchronous active-high reset
//   cnt           in   [0:N-1] Johnson code, cnt[0] is the shift-in bit
//   err_clr       in   pulse that clears a fault (honoured only in FAULT)
//   phase_idx     out  decoded phase 0..2N-1
//   phase_onehot  out  one-hot phase, zero unless phase_valid
//   phase_valid   out  high while LOCKED
//   locked        out  high while LOCKED
//   err           out  sticky fault flag
//   cycle_tick    out  one-cycle pulse on the 2N-1 -> 0 wrap
//   cycle_cnt     out  [CYC_W-1:0] revolution count (JC_CYCLE_COUNT_EN only)

module jc_phase_decoder
  import jc_pkg::*;
#(
  parameter int N     = 4,
  parameter int CYC_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [0:N-1]                   cnt,
  input  logic                           err_clr,
  output logic [$clog2(jc_phases(N))-1:0] phase_idx,
  output logic [jc_phases(N)-1:0]        phase_onehot,
  output logic                           phase_valid,
  output logic                           locked,
  output logic                           err,
  output logic                           cycle_tick
`ifdef JC_CYCLE_COUNT_EN
  ,
  output logic [CYC_W-1:0]               cycle_cnt
`endif
);

  localparam int              PH   = jc_phases(N);
  localparam int              IDXW = $clog2(PH);
  localparam logic [IDXW-1:0] LAST = IDXW'(PH - 1);

  if (N < 2 || CYC_W < 1) begin : g_param_check
    $error("jc_phase_decoder: N must be >= 2 and CYC_W >= 1");
  end

  jc_state_e       state;
  logic [IDXW-1:0] prev_idx;
  logic            have_prev;   // a legal sample has been seen in SYNC

  jc_dec_t         dec;
  logic [IDXW-1:0] dec_idx;
  logic [IDXW-1:0] next_idx;
  logic            step_ok;
  logic            unused_dec_hi;

  jc_code_decode #(.N(N)) u_decode (
    .cnt (cnt),
    .dec (dec)
  );

  assign dec_idx       = dec.idx[IDXW-1:0];
  assign unused_dec_hi = ^dec.idx;

  // A hold is legal (the counter may sit in reset); otherwise only +1 mod 2N.
  assign next_idx = (prev_idx == LAST) ? '0 : prev_idx + 1'b1;
  assign step_ok  = (dec_idx == prev_idx) || (dec_idx == next_idx);

  function automatic logic [PH-1:0] onehot_of(input logic [IDXW-1:0] i);
    return PH'(1) << i;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SYNC;
      prev_idx     <= '0;
      have_prev    <= 1'b0;
      phase_idx    <= '0;
      phase_onehot <= '0;
      phase_valid  <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      cycle_tick   <= 1'b0;
`ifdef JC_CYCLE_COUNT_EN
      cycle_cnt    <= '0;
`endif
    end else begin
      cycle_tick <= 1'b0;
      case (state)
        SYNC: begin
          phase_valid  <= 1'b0;
          locked       <= 1'b0;
          phase_onehot <= '0;
          if (!dec.legal) begin
            have_prev <= 1'b0;
          end else begin
            prev_idx <= dec_idx;
            if (have_prev && step_ok) begin
              state        <= LOCKED;
              have_prev    <= 1'b0;
              phase_idx    <= dec_idx;
              phase_onehot <= onehot_of(dec_idx);
              phase_valid  <= 1'b1;
              locked       <= 1'b1;
            end else begin
              // A bad step restarts the pair with this sample as the first.
              have_prev <= 1'b1;
            end
          end
        end

        LOCKED: begin
          if (dec.legal && step_ok) begin
            prev_idx     <= dec_idx;
            phase_idx    <= dec_idx;
            phase_onehot <= onehot_of(dec_idx);
            // phase_idx is the last accepted phase, so a hold at 0 never ticks.
            if (phase_idx == LAST && dec_idx == '0) begin
              cycle_tick <= 1'b1;
`ifdef JC_CYCLE_COUNT_EN
              cycle_cnt  <= cycle_cnt + 1'b1;
`endif
            end
          end else begin
            // Fault wins over a simultaneous err_clr; phase_idx stays frozen.
            state        <= FAULT;
            err          <= 1'b1;
            phase_valid  <= 1'b0;
            locked       <= 1'b0;
            phase_onehot <= '0;
          end
        end

        FAULT: begin
          if (err_clr) begin
            state     <= SYNC;
            err       <= 1'b0;
            have_prev <= 1'b0;
          end
        end

        default: begin
          state        <= SYNC;
          have_prev    <= 1'b0;
          phase_valid  <= 1'b0;
          locked       <= 1'b0;
          phase_onehot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jc_phase_decoder.sv
// tb/tb_jc_phase_decoder.sv - directed self-checking bench for jc_phase_decoder

module tb_jc_phase_decoder;

  logic       clk;
  logic       rst;
  logic [0:3] cnt;
  logic       err_clr;
  logic [2:0] phase_idx;
  logic [7:0] phase_onehot;
  logic       phase_valid;
  logic       locked;
  logic       err;
  logic       cycle_tick;
`ifdef JC_CYCLE_COUNT_EN
  logic [7:0] cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] codes [8];

  jc_phase_decoder #(.N(4), .CYC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cnt          (cnt),
    .err_clr      (err_clr),
    .phase_idx    (phase_idx),
    .phase_onehot (phase_onehot),
    .phase_valid  (phase_valid),
    .locked       (locked),
    .err          (err),
    .cycle_tick   (cycle_tick)
`ifdef JC_CYCLE_COUNT_EN
    ,
    .cycle_cnt    (cycle_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked at that point.
  task automatic step(input logic [3:0] c);
    cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idx"},    32'(phase_idx),    32'h0);
    chk({tag, "_onehot"}, 32'(phase_onehot), 32'h0);
    chk({tag, "_valid"},  32'(phase_valid),  32'h0);
    chk({tag, "_locked"}, 32'(locked),       32'h0);
    chk({tag, "_err"},    32'(err),          32'h0);
    chk({tag, "_tick"},   32'(cycle_tick),   32'h0);
  endtask

  initial begin
    int tick_count;
    int bad_idx;
    int bad_cc;

    codes[0] = 4'b0000; codes[1] = 4'b1000; codes[2] = 4'b1100; codes[3] = 4'b1110;
    codes[4] = 4'b1111; codes[5] = 4'b0111; codes[6] = 4'b0011; codes[7] = 4'b0001;

    // Reset with no clock edge yet.
    rst = 1'b1;
    cnt = 4'b0000;
    err_clr = 1'b0;
    #2;
    chk_all_zero("reset");
`ifdef JC_CYCLE_COUNT_EN
    chk("reset_cc", 32'(cycle_cnt), 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two samples of 0000 lock.
    step(4'b0000);
    chk("lock1_locked", 32'(locked), 32'h0);
    step(4'b0000);
    chk("lock2_locked", 32'(locked), 32'h1);
    chk("lock2_valid",  32'(phase_valid), 32'h1);
    chk("lock2_idx",    32'(phase_idx), 32'h0);
    chk("lock2_onehot", 32'(phase_onehot), 32'h01);

    // One full revolution.
    for (int k = 1; k <= 8; k++) begin
      step(codes[k % 8]);
      chk($sformatf("rev_idx_%0d", k), 32'(phase_idx), 32'(k % 8));
      chk($sformatf("rev_tick_%0d", k), 32'(cycle_tick), (k == 8) ? 32'h1 : 32'h0);
    end
    chk("rev_onehot_end", 32'(phase_onehot), 32'h01);
`ifdef JC_CYCLE_COUNT_EN
    chk("rev_cc", 32'(cycle_cnt), 32'h1);
`endif
    step(4'b0000);
    chk("hold0_tick", 32'(cycle_tick), 32'h0);
    chk("hold0_locked", 32'(locked), 32'h1);

    // Illegal code while at idx 2.
    step(4'b1000);
    step(4'b1100);
    chk("pre_bad_idx", 32'(phase_idx), 32'h2);
    step(4'b1010);
    chk("bad_err",    32'(err), 32'h1);
    chk("bad_locked", 32'(locked), 32'h0);
    chk("bad_valid",  32'(phase_valid), 32'h0);
    chk("bad_onehot", 32'(phase_onehot), 32'h0);
    chk("bad_idx",    32'(phase_idx), 32'h2);
    step(4'b1110);
    chk("fault_hold_err",    32'(err), 32'h1);
    chk("fault_hold_locked", 32'(locked), 32'h0);
    err_clr = 1'b1;
    step(4'b0000);
    err_clr = 1'b0;
    chk("clr_err",    32'(err), 32'h0);
    chk("clr_locked", 32'(locked), 32'h0);
    step(4'b0000);
    chk("relock1_locked", 32'(locked), 32'h0);
    step(4'b0000);
    chk("relock2_locked", 32'(locked), 32'h1);
    chk("relock2_idx",    32'(phase_idx), 32'h0);

    // Illegal jump 1 -> 3 with err_clr on the same edge.
    step(4'b1000);
    chk("jump_pre_idx", 32'(phase_idx), 32'h1);
    err_clr = 1'b1;
    step(4'b1110);
    err_clr = 1'b0;
    chk("jump_err",    32'(err), 32'h1);
    chk("jump_locked", 32'(locked), 32'h0);
    chk("jump_idx",    32'(phase_idx), 32'h1);
    step(4'b1111);
    chk("jump_sticky_err", 32'(err), 32'h1);
    err_clr = 1'b1;
    step(4'b0000);
    err_clr = 1'b0;
    step(4'b0000);
    step(4'b0000);
    chk("jump_relock", 32'(locked), 32'h1);

    // 256 revolutions; cycle_cnt was 1, so it wraps 255 -> 0 at revolution 254.
    tick_count = 0;
    bad_idx = 0;
    bad_cc = 0;
    for (int r = 0; r < 256; r++) begin
      for (int k = 1; k <= 8; k++) begin
        step(codes[k % 8]);
        if (cycle_tick === 1'b1) tick_count++;
        if (phase_idx !== 3'(k % 8)) bad_idx++;
      end
`ifdef JC_CYCLE_COUNT_EN
      if (cycle_cnt !== 8'((2 + r) % 256)) bad_cc++;
      if (r == 253) chk("wrap_cc_255", 32'(cycle_cnt), 32'hff);
      if (r == 254) begin
        chk("wrap_cc_0",   32'(cycle_cnt), 32'h0);
        chk("wrap_tick",   32'(cycle_tick), 32'h1);
      end
`endif
    end
    chk("revs_tick_count", 32'(tick_count), 32'd256);
    chk("revs_bad_idx",    32'(bad_idx), 32'h0);
`ifdef JC_CYCLE_COUNT_EN
    chk("revs_bad_cc",     32'(bad_cc), 32'h0);
`endif

    // Asynchronous reset while locked at idx 5.
    for (int k = 1; k <= 5; k++) step(codes[k]);
    chk("pre_rst_idx",    32'(phase_idx), 32'h5);
    chk("pre_rst_onehot", 32'(phase_onehot), 32'h20);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
`ifdef JC_CYCLE_COUNT_EN
    chk("async_rst_cc", 32'(cycle_cnt), 32'h0);
`endif
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_locked0", 32'(locked), 32'h0);
    step(4'b0000);
    chk("post_rst_locked1", 32'(locked), 32'h0);
    step(4'b1000);
    chk("post_rst_locked2", 32'(locked), 32'h1);
    chk("post_rst_idx",     32'(phase_idx), 32'h1);
    chk("post_rst_onehot",  32'(phase_onehot), 32'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
